// File: rtl/fwd_pkg.sv
// Shared widths, forwarding-select encodings and pipeline shadow-slot payloads
// for the EX-stage operand forwarding logic.
package fwd_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } idex_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } exmem_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
  } memwb_t;

endpackage

// File: rtl/fwd_prio_cmp.sv
// Two-candidate forwarding compare: the nearer (newer) producer wins over the
// farther one, and x0 is never forwarded.
module fwd_prio_cmp
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              near_v,
  input  logic              near_rw,
  input  logic [REG_AW-1:0] near_rd,
  input  logic              far_v,
  input  logic              far_rw,
  input  logic [REG_AW-1:0] far_rd,
  output logic [FWD_W-1:0]  sel_c
);

  logic near_hit;
  logic far_hit;

  always_comb begin
    near_hit = near_v & near_rw & (near_rd != '0) & (near_rd == rs);
    far_hit  = far_v  & far_rw  & (far_rd  != '0) & (far_rd  == rs);
    sel_c    = FWD_RF;
    if (near_hit) begin
      sel_c = FWD_EXMEM;
    end else if (far_hit) begin
      sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_select_gen.sv
// Forwarding-select and load-use hazard generator; shadows the ID/EX, EX/MEM and
// MEM/WB destination info and registers the selects for the instruction entering EX.
module forward_select_gen
  import fwd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              mem_stall_i,
  output logic [FWD_W-1:0]  forward_a_o,
  output logic [FWD_W-1:0]  forward_b_o,
  output logic              stall_o
);

  idex_t            idex;
  exmem_t           exmem;
  memwb_t           memwb;
  logic [FWD_W-1:0] sel_a_c;
  logic [FWD_W-1:0] sel_b_c;
  logic             unused_slot_bits;

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    stall_o = rst_i & id_valid_i & idex.v & idex.mr & (idex.rd != '0) &
              ((idex.rd == id_rs1_i) | (idex.rd == id_rs2_i));
  end

  fwd_prio_cmp u_cmp_a (
    .rs      (id_rs1_i),
    .near_v  (idex.v),
    .near_rw (idex.rw),
    .near_rd (idex.rd),
    .far_v   (exmem.v),
    .far_rw  (exmem.rw),
    .far_rd  (exmem.rd),
    .sel_c   (sel_a_c)
  );

  fwd_prio_cmp u_cmp_b (
    .rs      (id_rs2_i),
    .near_v  (idex.v),
    .near_rw (idex.rw),
    .near_rd (idex.rd),
    .far_v   (exmem.v),
    .far_rw  (exmem.rw),
    .far_rd  (exmem.rd),
    .sel_c   (sel_b_c)
  );

  // Slots advance together unless the D-cache freezes the whole pipeline.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex        <= '0;
      exmem       <= '0;
      memwb       <= '0;
      forward_a_o <= FWD_RF;
      forward_b_o <= FWD_RF;
    end else if (!mem_stall_i) begin
      memwb <= '{v: exmem.v, rd: exmem.rd, rw: exmem.rw};
      exmem <= '{v: idex.v, rd: idex.rd, rw: idex.rw, mr: idex.mr};
      if (stall_o) begin
        idex <= '0;
      end else begin
        idex <= '{v: id_valid_i, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                  rw: id_regwrite_i, mr: id_memread_i};
      end
      forward_a_o <= (stall_o || !id_valid_i) ? FWD_RF : sel_a_c;
      forward_b_o <= (stall_o || !id_valid_i) ? FWD_RF : sel_b_c;
    end
  end

  // Shadow fields kept for pipeline visibility but not needed by the select logic.
  assign unused_slot_bits = ^{memwb, exmem.mr, idex.rs1, idex.rs2};

endmodule
